// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM with memory wait-state handshake and wait watchdog.
// Optional ILLEGAL_OP_TRAP_EN: unknown opcodes park the FSM in TRAP and drive illegal_op.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       mem_timeout,
    output logic [3:0] state
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
    // DECODE | branch target into ALUOut, dispatch on OP
    // MEMADR | effective address for LW/SW
    // MEMRD  | data read, waits for mem_ready
    // MEMWB  | MDR -> rt
    // MEMWR  | data write, waits for mem_ready
    // RTEXEC | R-type ALU operation
    // ALUWB  | ALUOut -> rd
    // BRANCH | compare, conditional PC load
    // IEXEC  | immediate ALU operation
    // IWB    | ALUOut -> rt
    // JUMP   | PC <= jump target
    // JR     | PC <= rs
    // JAL    | PC <= jump target, $31 <= PC+4
    // TRAP   | illegal opcode, held until reset
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
        S_JR     = 4'd12, S_JAL    = 4'd13, S_TRAP   = 4'd14
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_mem_state;
    logic             w_abort;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Abort on the WAIT_LIMIT-th consecutive not-ready cycle; a ready in that cycle wins.
    assign w_abort = w_mem_state && !mem_ready && (r_cnt == CNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_abort;
            if (w_mem_state && !mem_ready && !w_abort)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_abort) w_next = S_FETCH;
                      else if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (OP)
                    6'h00:                      w_next = (func == 6'h08) ? S_JR : S_RTEXEC;
                    6'h23, 6'h2B:               w_next = S_MEMADR;
                    6'h08, 6'h0D, 6'h0C, 6'h0F: w_next = S_IEXEC;
                    6'h04, 6'h05:               w_next = S_BRANCH;
                    6'h02:                      w_next = S_JUMP;
                    6'h03:                      w_next = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                    w_next = S_TRAP;
`else
                    default:                    w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_next = (OP == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (w_abort) w_next = S_FETCH;
                      else if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (w_abort || mem_ready) w_next = S_FETCH;
            S_RTEXEC: w_next = S_ALUWB;
            S_IEXEC:  w_next = S_IWB;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 2'd0;
        MemtoReg = 2'd0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        ALUOp    = 3'b000;
        PCSource = 2'd0;
        PCWrite  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = 3'b100;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'd3;
                    ALUOp   = 3'b100;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = 3'b100;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 2'd1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = mem_ready;
                end
                S_RTEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b111;
                end
                S_ALUWB: begin
                    RegDst   = 2'd1;
                    RegWrite = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    case (OP)
                        6'h0D:   ALUOp = 3'b101;
                        6'h0C:   ALUOp = 3'b110;
                        6'h0F:   ALUOp = 3'b001;
                        default: ALUOp = 3'b100;
                    endcase
                end
                S_IWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 3'b011;
                    PCSource = 2'd1;
                    PCWrite  = ((OP == 6'h04) && Zero) || ((OP == 6'h05) && !Zero);
                end
                S_JUMP: begin
                    PCSource = 2'd2;
                    PCWrite  = 1'b1;
                end
                S_JR: begin
                    PCSource = 2'd3;
                    PCWrite  = 1'b1;
                end
                S_JAL: begin
                    RegDst   = 2'd2;
                    MemtoReg = 2'd2;
                    RegWrite = 1'b1;
                    PCSource = 2'd2;
                    PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_timeout = r_timeout && !reset;
    assign state       = reset ? 4'd0 : r_state;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op  = (r_state == S_TRAP) && !reset;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: an instruction-level reference walk pushes
// per-cycle expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_control;
    localparam int WAIT_LIMIT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OP = 6'h00;
    logic [5:0] func = 6'h00;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite, mem_timeout;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .OP(OP), .func(func), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
        .mem_timeout(mem_timeout), .state(state)
`ifdef ILLEGAL_OP_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] exp;
        logic [22:0] mask;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_idx = 0;
    bit   pend_to = 0;

    // Output table per state, straight from the control schedule.
    function automatic logic [22:0] model(input logic [3:0] st, input logic [5:0] op,
                                          input logic z, input logic rdy, input logic rst,
                                          input logic to);
        logic iord, mr, mw, irw, rw, asa, pcw;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] aop;
        iord = 0; mr = 0; mw = 0; irw = 0; rw = 0; asa = 0; pcw = 0;
        rd = 0; m2r = 0; asb = 0; pcs = 0; aop = 0;
        case (st)
            4'd0:  begin mr = 1; asb = 2'd1; aop = 3'b100; irw = rdy; pcw = rdy; end
            4'd1:  begin asb = 2'd3; aop = 3'b100; end
            4'd2:  begin asa = 1; asb = 2'd2; aop = 3'b100; end
            4'd3:  begin iord = 1; mr = 1; end
            4'd4:  begin m2r = 2'd1; rw = 1; end
            4'd5:  begin iord = 1; mw = rdy; end
            4'd6:  begin asa = 1; aop = 3'b111; end
            4'd7:  begin rd = 2'd1; rw = 1; end
            4'd8:  begin asa = 1; aop = 3'b011; pcs = 2'd1;
                         pcw = (op == 6'h04) ? z : !z; end
            4'd9:  begin asa = 1; asb = 2'd2;
                         aop = (op == 6'h0D) ? 3'b101 : (op == 6'h0C) ? 3'b110 :
                               (op == 6'h0F) ? 3'b001 : 3'b100; end
            4'd10: rw = 1;
            4'd11: begin pcs = 2'd2; pcw = 1; end
            4'd12: begin pcs = 2'd3; pcw = 1; end
            4'd13: begin rd = 2'd2; m2r = 2'd2; rw = 1; pcs = 2'd2; pcw = 1; end
            default: ;
        endcase
        if (rst) return '0;
        return {st, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcw, to};
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic [3:0] st);
        exp_t e;
        logic mem_st;
        reset     = rst;
        mem_ready = rdy;
        mem_st    = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
        e.exp  = model(st, OP, Zero, rdy, rst, pend_to && !rst);
        // The read strobe while a memory access is still waiting is not pinned down.
        e.mask = {4'hF, 1'b1, !(mem_st && !rdy && !rst), 17'h1FFFF};
        e.idx  = cur_idx;
        pend_to = 0;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One memory access that sees `waits` not-ready cycles before ready.
    task automatic mem_phase(input logic [3:0] st, input int waits, output bit done);
        int  w;
        bit  ab;
        w = 0; ab = 0; done = 0;
        while (!done && !ab) begin
            if (w < waits) begin
                step(1'b0, 1'b0, st);
                w++;
                if (w == WAIT_LIMIT) begin
                    pend_to = 1;
                    ab = 1;
                end
            end else begin
                step(1'b0, 1'b1, st);
                done = 1;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        bit done;
        cur_idx++;
        OP = op; func = fn; Zero = z;
        mem_phase(4'd0, fw, done);
        while (!done) mem_phase(4'd0, 0, done);
        step(1'b0, 1'b1, 4'd1);
        case (op)
            6'h23: begin
                step(1'b0, 1'b1, 4'd2);
                mem_phase(4'd3, mw, done);
                if (done) step(1'b0, 1'b1, 4'd4);
            end
            6'h2B: begin
                step(1'b0, 1'b1, 4'd2);
                mem_phase(4'd5, mw, done);
            end
            6'h00: begin
                if (fn == 6'h08) step(1'b0, 1'b1, 4'd12);
                else begin step(1'b0, 1'b1, 4'd6); step(1'b0, 1'b1, 4'd7); end
            end
            6'h08, 6'h0D, 6'h0C, 6'h0F: begin
                step(1'b0, 1'b1, 4'd9); step(1'b0, 1'b1, 4'd10);
            end
            6'h04, 6'h05: step(1'b0, 1'b1, 4'd8);
            6'h02: step(1'b0, 1'b1, 4'd11);
            6'h03: step(1'b0, 1'b1, 4'd13);
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                repeat (3) step(1'b0, $urandom_range(0, 1) == 1, 4'd14);
`endif
            end
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [22:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {state, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, mem_timeout};
            n_chk++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL outputs instr#%0d t=%0t: got st=%0d vec=%h, expected st=%0d vec=%h (mask %h)",
                         e.idx, $time, act[22:19], act, e.exp[22:19], e.exp, e.mask);
            end
`ifdef ILLEGAL_OP_TRAP_EN
            n_chk++;
            if (illegal_op !== (e.exp[22:19] == 4'd14)) begin
                n_fail++;
                $display("FAIL illegal_op instr#%0d: got %b expected %b", e.idx, illegal_op,
                         e.exp[22:19] == 4'd14);
            end
`endif
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[$];
        logic [5:0] op, fn;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h0C, 6'h0F,
                6'h04, 6'h05, 6'h02, 6'h03};
`ifndef ILLEGAL_OP_TRAP_EN
        ops.push_back(6'h3F);
        ops.push_back(6'h11);
`endif
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);

        run_instr(6'h23, 6'h00, 1'b0, 0, 0);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h20, 1'b0, 3, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 40);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0);
        run_instr(6'h0C, 6'h00, 1'b0, 0, 0);
        run_instr(6'h0F, 6'h00, 1'b0, 0, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 2);
        run_instr(6'h23, 6'h00, 1'b0, WAIT_LIMIT - 1, WAIT_LIMIT - 1);
        run_instr(6'h23, 6'h00, 1'b0, 0, WAIT_LIMIT);
        run_instr(6'h00, 6'h22, 1'b0, WAIT_LIMIT + 3, 0);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 50; i++) begin
            op = ops[$urandom_range(0, ops.size() - 1)];
            fn = 6'($urandom_range(0, 63));
            if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
            else if (op == 6'h00 && fn == 6'h08) fn = 6'h20;
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? WAIT_LIMIT + 1 : $urandom_range(0, 2),
                      ($urandom_range(0, 7) == 0) ? WAIT_LIMIT : $urandom_range(0, 3));
        end

        step(1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b1, 4'd0);
`ifdef ILLEGAL_OP_TRAP_EN
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
`endif
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing FSM for the multi-cycle MIPS datapath. The datapath shares one memory, one ALU and one instruction register.
- Replaces per-instruction combinational decode with a per-state strobe schedule: fetch, decode, execute, memory, writeback.
- Adds memory wait-state handshake (mem_ready) and a wait-timeout watchdog.
- Sits between the instruction register (OP/func), ALU flag Zero, unified memory and the datapath muxes/enables.

Parameters:
- WAIT_LIMIT, 15, max cycles a memory state waits for mem_ready before abort (1..255).
- CNT_W, 8, width of the wait counter; WAIT_LIMIT must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- OP  in  6  opcode from the instruction register.
- func  in  6  function field from the instruction register.
- Zero  in  1  ALU zero flag, valid in the BRANCH state.
- mem_ready  in  1  memory access completes this cycle.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load the instruction register.
- RegDst  out  2  write register: 0=rt, 1=rd, 2=$31.
- MemtoReg  out  2  write data: 0=ALUOut, 1=MDR, 2=PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=rs.
- ALUSrcB  out  2  0=rt, 1=const 4, 2=sign-extended imm, 3=imm<<2.
- ALUOp  out  3  111 R-type(func), 100 add, 101 or, 110 and, 001 lui, 011 sub.
- PCSource  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=rs.
- PCWrite  out  1  PC load enable; branch condition is already resolved inside this block.
- mem_timeout  out  1  one-cycle pulse when a memory wait is aborted.
- state  out  4  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JR=12, JAL=13, TRAP=14.
- Reset: on clk edge with reset=1, state<=FETCH, wait counter<=0, mem_timeout<=0. While reset=1, all strobe outputs (MemRead, MemWrite, IRWrite, RegWrite, PCWrite) are forced 0. All other outputs are 0 during reset.
- Outputs are combinational from state; in FETCH/MEMRD/MEMWR they are additionally gated by mem_ready. Unlisted outputs are 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=100, PCSource=0.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=100 (branch target into ALUOut). Next state by OP:
  - 0x00 with func=0x08 -> JR; other OP=0x00 -> RTEXEC.
  - 0x23/0x2B -> MEMADR.
  - 0x08/0x0D/0x0C/0x0F -> IEXEC.
  - 0x04/0x05 -> BRANCH.
  - 0x02 -> JUMP; 0x03 -> JAL.
  - Any other opcode -> FETCH (NOP) unless ILLEGAL_OP_TRAP_EN.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=100. -> MEMRD if LW, MEMWR if SW.
- MEMRD: IorD=1, MemRead=1. mem_ready -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1. mem_ready -> FETCH.
- RTEXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=111 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=2. ALUOp = 100 (ADDI), 101 (ORI), 110 (ANDI), 001 (LUI) -> IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=011, PCSource=1.
  - PCWrite = (OP==0x04 & Zero) | (OP==0x05 & ~Zero).
  - -> FETCH.
- JUMP: PCSource=2, PCWrite=1 -> FETCH.
- JR: PCSource=3, PCWrite=1 -> FETCH.
- JAL: RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2, PCWrite=1 -> FETCH. The PC write and the link write occur in the same cycle; the link value is the pre-update PC+4.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR and on mem_ready.
  - Increments each cycle the FSM is in a memory state with mem_ready=0.
  - If the counter reaches WAIT_LIMIT with mem_ready=0: mem_timeout=1 next cycle for exactly one cycle, and FSM -> FETCH with no IRWrite/PCWrite/RegWrite/MemWrite issued.
  - A timed-out FETCH retries the same PC.
  - mem_ready and the limit in the same cycle: mem_ready wins, no timeout.
- OP/func are sampled only in DECODE and later states. The instruction register is stable from DECODE until the next FETCH completes.
- Latencies (mem_ready=1 immediately):
  - LW 5 cycles.
  - SW, R-type, I-type: 4 cycles.
  - BEQ/BNE, J, JR, JAL: 3 cycles.

Optional Feature:
- ILLEGAL_OP_TRAP_EN:
  - Defined: unrecognised OP in DECODE -> TRAP. TRAP holds all strobes 0 and stays there until reset. Output illegal_op (1 bit) is added and is 1 while in TRAP.
  - Undefined: unrecognised OP -> FETCH, treated as a NOP; no illegal_op port exists.

Test Plan:
- Reset held 2 cycles with mem_ready=1 -> all strobes 0, state=0; on the first cycle after release, IRWrite=PCWrite=MemRead=1.
- LW (OP=0x23), mem_ready=1 always -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with MemtoReg=1.
- BEQ (OP=0x04): Zero=1 -> PCWrite=1 in BRANCH. Repeat with Zero=0 -> PCWrite=0. BNE inverts both results.
- FETCH with mem_ready=0 for 3 cycles, then 1 -> IRWrite pulses once in cycle 4; mem_timeout stays 0.
- WAIT_LIMIT=15 with mem_ready stuck 0 in MEMWR -> mem_timeout pulses once; MemWrite never completes; state returns to 0.
- JAL (OP=0x03) -> state 0,1,13; in state 13 RegWrite=1, RegDst=2, PCWrite=1. OP=0x3F -> FETCH when the macro is undefined; state 14 with illegal_op=1 when it is defined.
